// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit feeding the decode stage.
// Latency: a request accepted in cycle N gives inst_valid in cycle N+2 at the earliest.
// Backpressure: one imem request in flight; a held instruction blocks further fetch until decode takes it.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   redirect_valid, redirect_target  taken branch/jump; restarts fetch at the target
//   imem_req_valid/ready/addr        instruction request (valid/ready handshake)
//   imem_resp_valid/data             response, exactly one per accepted request
//   inst_valid/ready, inst, inst_pc  instruction offered to decode (valid/ready handshake)
//   misalign                         sticky misaligned-redirect trap flag
//
// Build option IFU_MISALIGN_CHECK_EN: when defined, a redirect to a target that is not
// word aligned parks the unit in TRAP (misalign=1, no fetch) until reset. When undefined
// the low two target bits are ignored and misalign is constant 0.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_TRAP
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        drop_q;     // the response still in flight belongs to a squashed path
  logic        req_vld_q;
  logic        inst_vld_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;

  logic [31:0] redir_tgt;
  logic        redir_bad;

`ifdef IFU_MISALIGN_CHECK_EN
  // A misaligned target never reaches pc_q: it diverts to TRAP instead.
  assign redir_tgt = redirect_target;
  assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign misalign  = (state_q == S_TRAP);
`else
  assign redir_tgt = redirect_target & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
  assign misalign  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      req_vld_q  <= 1'b0;
      inst_vld_q <= 1'b0;
      inst_q     <= 32'h0;
      inst_pc_q  <= 32'h0;
    end else if (redir_bad && (state_q != S_TRAP)) begin
      state_q    <= S_TRAP;
      drop_q     <= 1'b0;
      req_vld_q  <= 1'b0;
      inst_vld_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q   <= S_REQ;
          req_vld_q <= 1'b1;
          if (redirect_valid) pc_q <= redir_tgt;
        end

        S_REQ: begin
          // Responses seen here are leftovers from before a reset; they are ignored.
          if (redirect_valid) begin
            pc_q <= redir_tgt;
            if (imem_req_ready) begin
              // The old address was accepted in the same cycle: squash its response.
              state_q   <= S_WAIT;
              req_vld_q <= 1'b0;
              drop_q    <= 1'b1;
            end
            // Without a handshake the request simply moves to the new address.
          end else if (imem_req_ready) begin
            state_q   <= S_WAIT;
            req_vld_q <= 1'b0;
          end
        end

        S_WAIT: begin
          if (imem_resp_valid) begin
            if (redirect_valid || drop_q) begin
              state_q   <= S_REQ;
              req_vld_q <= 1'b1;
              drop_q    <= 1'b0;
            end else begin
              state_q    <= S_HOLD;
              inst_vld_q <= 1'b1;
              inst_q     <= imem_resp_data;
              inst_pc_q  <= pc_q;
            end
            if (redirect_valid) pc_q <= redir_tgt;
          end else if (redirect_valid) begin
            pc_q   <= redir_tgt;
            drop_q <= 1'b1;
          end
        end

        S_HOLD: begin
          // A redirect wins even if decode accepts in the same cycle.
          if (redirect_valid) begin
            pc_q       <= redir_tgt;
            state_q    <= S_REQ;
            req_vld_q  <= 1'b1;
            inst_vld_q <= 1'b0;
          end else if (inst_ready) begin
            pc_q       <= pc_q + 32'd4;
            state_q    <= S_REQ;
            req_vld_q  <= 1'b1;
            inst_vld_q <= 1'b0;
          end
        end

        S_TRAP: begin
          // Parked until reset.
          req_vld_q  <= 1'b0;
          inst_vld_q <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          req_vld_q  <= 1'b0;
          inst_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_vld_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_vld_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed and randomized checks of ifu_fetch against an instruction-stream model.
// The model only knows that decode must see mem[pc], mem[pc+4], ... restarting at each redirect target.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  // memory responder state
  bit          mem_rand = 1'b0;
  bit          mem_rdy  = 1'b0;
  int          lat_min  = 0;
  int          lat_max  = 0;
  bit          pend     = 1'b0;
  int          pend_dly = 0;
  logic [31:0] pend_addr = 32'h0;

  // instruction-stream model
  logic [31:0] exp_pc = RST_PC;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_inst = 32'h0;
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] req_log[$];
  logic [31:0] ret_log[$];

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .misalign        (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "simulation timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    if (i >= 0 && i < req_log.size()) return req_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory, apply the stream model to this cycle's handshakes,
  // then advance to just after the next rising edge.
  task automatic tick();
    logic rq, rs, ia, rd;
    imem_req_ready  = mem_rand ? ($urandom_range(3, 0) != 0) : mem_rdy;
    imem_resp_valid = pend && (pend_dly == 0);
    imem_resp_data  = imem_resp_valid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    rq = imem_req_valid && imem_req_ready;
    rs = imem_resp_valid;
    ia = inst_valid && inst_ready;
    rd = redirect_valid;

    if (prev_hold) begin
      chk("hold_valid", inst_valid, 1'b1);
      chk("hold_inst", inst, prev_inst);
      chk("hold_pc", inst_pc, prev_pc);
    end
    prev_hold = inst_valid && !inst_ready && !rd && rst_n;
    prev_inst = inst;
    prev_pc   = inst_pc;

    if (rq) req_log.push_back(imem_req_addr);
    if (ia && !rd && rst_n) begin
      chk("retire_pc", inst_pc, exp_pc);
      chk("retire_data", inst, mem_word(inst_pc));
      ret_log.push_back(inst_pc);
      exp_pc = inst_pc + 32'd4;
    end
    if (rd && rst_n) exp_pc = redirect_target & 32'hFFFF_FFFC;

    if (rs) pend = 1'b0;
    else if (pend) pend_dly--;
    if (rq) begin
      chk("one_outstanding", pend, 1'b0);
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_dly  = int'($urandom_range(lat_max, lat_min));
    end

    @(posedge clk);
    #1;
  endtask

  // Reset with state checks; a response still in flight is delivered after release
  // while the unit sits in IDLE/REQ and must be ignored.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    mem_rand       = 1'b0;
    mem_rdy        = 1'b0;
    prev_hold      = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_misalign", misalign, 1'b0);
    rst_n  = 1'b1;
    exp_pc = RST_PC;
    for (int k = 0; k < 20; k++) begin
      if (!pend) break;
      tick();
    end
    req_log.delete();
    ret_log.delete();
  endtask

  initial begin
    int          first_iv;
    int          idx;
    int          n0;
    logic [31:0] hp;
    logic [31:0] hi;
    bit          seen;

    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    #1;
    chk("async_rst_req_valid", imem_req_valid, 1'b0);
    chk("async_rst_inst_valid", inst_valid, 1'b0);

    // Back-to-back fetch with an always-ready memory and 1-cycle responses.
    do_reset();
    mem_rdy = 1'b1; lat_min = 0; lat_max = 0; inst_ready = 1'b1;
    first_iv = -1;
    for (int i = 0; i < 12; i++) begin
      if (inst_valid && first_iv < 0) first_iv = i;
      tick();
    end
    chk("first_inst_latency", first_iv, 3);
    chk("seq_req0", req_at(0), 32'h8000_0000);
    chk("seq_req1", req_at(1), 32'h8000_0004);
    chk("seq_req2", req_at(2), 32'h8000_0008);

    // Redirect while waiting for the 8000_0004 response.
    do_reset();
    mem_rdy = 1'b1; lat_min = 1; lat_max = 1; inst_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (imem_req_valid && imem_req_addr == 32'h8000_0004) break;
      tick();
    end
    chk("wait_reach", imem_req_valid && (imem_req_addr == 32'h8000_0004), 1'b1);
    idx = req_log.size();
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("wait_req_old", req_at(idx), 32'h8000_0004);
    chk("wait_req_new", req_at(idx + 1), 32'h8000_0100);
    seen = 1'b0;
    foreach (ret_log[j]) if (ret_log[j] == 32'h8000_0004) seen = 1'b1;
    chk("wait_dropped", seen, 1'b0);

    // Redirect in HOLD with decode accepting in the same cycle.
    do_reset();
    mem_rdy = 1'b1; lat_min = 0; lat_max = 2;
    for (int k = 0; k < 30; k++) begin
      if (inst_valid) break;
      tick();
    end
    chk("hold_reach", inst_valid, 1'b1);
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h8000_0040;
    n0  = ret_log.size();
    idx = req_log.size();
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_valid", inst_valid, 1'b0);
    chk("hold_redir_count", ret_log.size(), n0);
    for (int k = 0; k < 10; k++) begin
      if (req_log.size() > idx) break;
      tick();
    end
    chk("hold_redir_req", req_at(idx), 32'h8000_0040);

    // Decode stalls for 5 cycles.
    inst_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (inst_valid) break;
      tick();
    end
    chk("stall_reach", inst_valid, 1'b1);
    hp = inst_pc; hi = inst; n0 = req_log.size();
    for (int k = 0; k < 5; k++) begin
      chk("stall_no_req_valid", imem_req_valid, 1'b0);
      tick();
    end
    chk("stall_valid", inst_valid, 1'b1);
    chk("stall_pc", inst_pc, hp);
    chk("stall_inst", inst, hi);
    chk("stall_no_req", req_log.size(), n0);
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();

    // pc wraps from FFFF_FFFC to 0.
    do_reset();
    mem_rdy = 1'b1; lat_min = 0; lat_max = 0; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    idx = -1;
    foreach (req_log[j]) if (req_log[j] == 32'hFFFF_FFFC && idx < 0) idx = j;
    chk("wrap_seen", (idx >= 0), 1'b1);
    chk("wrap_next", req_at(idx + 1), 32'h0000_0000);

    // Misaligned redirect while a request waits without handshake.
    do_reset();
    mem_rdy = 1'b1; lat_min = 0; lat_max = 0; inst_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (imem_req_valid && imem_req_addr == 32'h8000_0008) break;
      tick();
    end
    chk("mis_reach", imem_req_valid && (imem_req_addr == 32'h8000_0008), 1'b1);
    mem_rdy = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h8000_0002;
    tick();
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_flag", misalign, 1'b1);
    mem_rdy = 1'b1;
    n0 = req_log.size();
    for (int k = 0; k < 8; k++) begin
      chk("mis_no_req_valid", imem_req_valid, 1'b0);
      chk("mis_no_inst", inst_valid, 1'b0);
      tick();
    end
    chk("mis_no_req", req_log.size(), n0);
    chk("mis_sticky", misalign, 1'b1);
`else
    chk("mis_flag", misalign, 1'b0);
    chk("mis_req_valid", imem_req_valid, 1'b1);
    chk("mis_req_addr", imem_req_addr, 32'h8000_0000);
    mem_rdy = 1'b1;
    n0 = ret_log.size();
    for (int k = 0; k < 10; k++) tick();
    chk("mis_retired", (ret_log.size() > n0), 1'b1);
`endif

    // Reset while a slow response is in flight.
    do_reset();
    mem_rdy = 1'b1; lat_min = 4; lat_max = 4; inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (pend) break;
      tick();
    end
    chk("midrst_pending", pend, 1'b1);
    do_reset();
    mem_rdy = 1'b1; lat_min = 0; lat_max = 1; inst_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (ret_log.size() > 0) break;
      tick();
    end
    chk("midrst_first_pc", (ret_log.size() > 0) ? ret_log[0] : 32'hxxxx_xxxx, RST_PC);

    // Randomized traffic against the stream model.
    do_reset();
    mem_rand = 1'b1; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      inst_ready     = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
`ifdef IFU_MISALIGN_CHECK_EN
      redirect_target = $urandom & 32'hFFFF_FFFC;
`else
      redirect_target = $urandom;
`endif
      tick();
    end
    redirect_valid = 1'b0;
    chk("random_progress", (ret_log.size() > 100), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
